// File: rtl/chunked_seq_adder_if.sv
// ---------------------------------------------------------------------------
// chunked_seq_adder_if
// Handshake and data bundle for chunked_seq_adder.
//   Operand side : in_valid, in_ready, a, b, cin
//   Result side  : out_valid, out_ready, sum, cout, all_prop
//   Status       : busy
// The slave modport is the adder's view; master is the view of whatever
// drives operands and consumes results.
// ---------------------------------------------------------------------------
interface chunked_seq_adder_if #(
    parameter int W = 8,
    parameter int N = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    logic           cin;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] sum;
    logic           cout;
    logic           all_prop;
    logic           busy;

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, all_prop, busy
    );

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, all_prop, busy
    );
endinterface

// File: rtl/chunked_seq_adder.sv
// ---------------------------------------------------------------------------
// chunked_seq_adder
// Multi-cycle N*W-bit adder built around a single W-bit adder. One W-bit
// slice is added per clock, low slice first, with the carry held in a
// register between slices.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : chunked_seq_adder_if.slave
//                operands a, b, cin accepted on in_valid & in_ready;
//                sum, cout, all_prop presented with out_valid until
//                out_ready; busy is high while an operation is in flight.
// ---------------------------------------------------------------------------

// W-bit full adder used for one slice per clock.
module b_bit_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

module chunked_seq_adder #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    chunked_seq_adder_if.slave    bus
);
    localparam int               IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    state_t           state_d;

    logic [N*W-1:0]   a_reg;
    logic [N*W-1:0]   b_reg;
    logic [N*W-1:0]   sum_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic             prop_q;
    logic             cout_q;
    logic             all_prop_q;

    logic [W-1:0]     chunk_a;
    logic [W-1:0]     chunk_b;
    logic [W-1:0]     chunk_sum;
    logic             chunk_cout;
    logic             chunk_prop;
    logic             last_chunk;

    assign chunk_a    = a_reg[int'(idx_q)*W +: W];
    assign chunk_b    = b_reg[int'(idx_q)*W +: W];
    assign chunk_prop = &(chunk_a ^ chunk_b);
    assign last_chunk = (idx_q == LAST_IDX);

    b_bit_adder #(.W(W)) u_chunk_adder (
        .a    (chunk_a),
        .b    (chunk_b),
        .cin  (carry_q),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = RUN;
            RUN:     if (last_chunk)   state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake / status outputs
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state_q)
            IDLE:    bus.in_ready  = 1'b1;
            RUN:     bus.busy      = 1'b1;
            DONE: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
            end
            default: bus.in_ready = 1'b0;
        endcase
    end

    // Operand capture and slice-by-slice accumulation. The result registers
    // are only written in RUN, so they hold steady in DONE and IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            sum_q      <= '0;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            prop_q     <= 1'b0;
            cout_q     <= 1'b0;
            all_prop_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg   <= bus.a;
                        b_reg   <= bus.b;
                        carry_q <= bus.cin;
                        idx_q   <= '0;
                        prop_q  <= 1'b1;
                    end
                end
                RUN: begin
                    sum_q[int'(idx_q)*W +: W] <= chunk_sum;
                    carry_q <= chunk_cout;
                    prop_q  <= prop_q & chunk_prop;
                    if (last_chunk) begin
                        idx_q      <= '0;
                        cout_q     <= chunk_cout;
                        all_prop_q <= prop_q & chunk_prop;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.all_prop = all_prop_q;
endmodule

// File: tb/tb_chunked_seq_adder.sv
// ---------------------------------------------------------------------------
// tb_chunked_seq_adder
// Directed and random stimulus for chunked_seq_adder (W=8, N=4). Expected
// results are queued when operands are issued; a monitor on the falling
// edge pops and compares on every result handoff.
// ---------------------------------------------------------------------------
module tb_chunked_seq_adder;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int OW = N * W;

    typedef struct packed {
        logic [OW-1:0] s;
        logic          c;
        logic          p;
    } exp_t;

    logic clk;
    logic rst_n;
    logic ready_val;
    logic rand_ready;

    int   n_checks;
    int   n_pass;
    int   n_handoff;
    exp_t exp_q[$];

    chunked_seq_adder_if #(.W(W), .N(N)) ifc ();

    chunked_seq_adder #(.W(W), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    endtask

    // Sink: out_ready changes shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        ifc.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
    end

    // Monitor: a handoff happens on the next rising edge whenever
    // out_valid & out_ready are both high mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ifc.out_valid && ifc.out_ready) begin
            n_handoff++;
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'(ifc.sum), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("sum", 64'(ifc.sum), 64'(e.s));
                check("cout", 64'(ifc.cout), 64'(e.c));
                check("all_prop", 64'(ifc.all_prop), 64'(e.p));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send(input logic [OW-1:0] av, input logic [OW-1:0] bv, input logic cv,
                        input logic push, input logic [OW-1:0] es, input logic ec, input logic ep);
        int k;
        k = 0;
        while (!ifc.in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (!ifc.in_ready) check("in_ready_timeout", 64'(ifc.in_ready), 64'd1);
        ifc.in_valid = 1'b1;
        ifc.a        = av;
        ifc.b        = bv;
        ifc.cin      = cv;
        if (push) exp_q.push_back('{s: es, c: ec, p: ep});
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || !ifc.in_ready) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [OW-1:0] ra;
        logic [OW-1:0] rb;
        logic          rc;
        logic [OW:0]   tot;
        int            lat;
        int            h0;
        logic          seen;

        n_checks     = 0;
        n_pass       = 0;
        n_handoff    = 0;
        ready_val    = 1'b1;
        rand_ready   = 1'b0;
        rst_n        = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.a        = '0;
        ifc.b        = '0;
        ifc.cin      = 1'b0;

        // Reset state
        #3;
        check("rst_in_ready", 64'(ifc.in_ready), 64'd1);
        check("rst_out_valid", 64'(ifc.out_valid), 64'd0);
        check("rst_busy", 64'(ifc.busy), 64'd0);
        check("rst_sum", 64'(ifc.sum), 64'd0);
        check("rst_cout_prop", 64'({ifc.cout, ifc.all_prop}), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Carry ripple through every slice, with latency measurement
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        check("busy_in_run", 64'({ifc.busy, ifc.in_ready}), 64'b10);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (ifc.out_valid) begin
                lat = k;
                break;
            end
        end
        check("latency", 64'(lat), 64'd4);
        drain("drain_ripple");

        // Full propagate, both carry-in values
        send(32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b1);
        send(32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        drain("drain_prop");

        // Backpressure: result must hold while out_ready is low
        ready_val = 1'b0;
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_6789, 1'b0, 1'b0);
        for (int k = 0; k < 20 && !ifc.out_valid; k++) begin
            @(posedge clk); #1;
        end
        h0 = n_handoff;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_hold", 64'({ifc.sum, ifc.cout, ifc.out_valid, ifc.in_ready}),
                  64'({32'h2345_6789, 1'b0, 1'b1, 1'b0}));
        end
        ready_val = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("bp_release", 64'({ifc.out_valid, ifc.in_ready}), 64'b01);
        @(posedge clk); #1;
        check("bp_single_handoff", 64'(n_handoff - h0), 64'd1);
        drain("drain_bp");

        // Back-to-back with in_valid held high and operands changing in RUN
        ifc.in_valid = 1'b1;
        ifc.a        = 32'h0102_0304;
        ifc.b        = 32'h1020_3040;
        ifc.cin      = 1'b0;
        exp_q.push_back('{s: 32'h1122_3344, c: 1'b0, p: 1'b0});
        @(posedge clk); #1;
        check("b2b_busy1", 64'(ifc.busy), 64'd1);
        ifc.a = 32'hDEAD_BEEF;
        ifc.b = 32'h0101_0101;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ifc.a   = 32'h8000_0000;
        ifc.b   = 32'h8000_0000;
        ifc.cin = 1'b1;
        exp_q.push_back('{s: 32'h0000_0001, c: 1'b1, p: 1'b0});
        h0 = n_handoff;
        for (int k = 0; k < 20 && !ifc.in_ready; k++) begin
            @(posedge clk); #1;
        end
        check("b2b_first_handoff", 64'(n_handoff - h0), 64'd1);
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        check("b2b_second_start", 64'({ifc.busy, ifc.in_ready}), 64'b10);
        drain("drain_b2b");

        // Asynchronous reset in the middle of RUN (idx==2)
        send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ctrl", 64'({ifc.in_ready, ifc.out_valid, ifc.busy}), 64'b100);
        check("mid_rst_data", 64'({ifc.sum, ifc.cout, ifc.all_prop}), 64'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            seen = seen | ifc.out_valid;
        end
        check("no_valid_after_abort", 64'(seen), 64'd0);
        send(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b1, 32'h0000_0007, 1'b0, 1'b0);
        drain("drain_after_rst");

        // Random regression with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra  = $urandom;
            rb  = (i % 50 == 0) ? ~ra : OW'($urandom);
            rc  = 1'($urandom_range(0, 1));
            tot = {1'b0, ra} + {1'b0, rb} + {{OW{1'b0}}, rc};
            send(ra, rb, rc, 1'b1, tot[OW-1:0], tot[OW], &(ra ^ rb));
        end
        drain("drain_random");
        rand_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
